// File: rtl/clk_burst_ctrl.sv
// Gated burst clock generator: emits repeat_cnt+1 bursts of burst_len fastclk/2 pulses,
// separated by gap_len extra low cycles, with abort, completion pulse and sticky abort flag.
module clk_burst_ctrl #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 8,
    parameter int REP_W = 4
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [GAP_W-1:0] gap_len,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             clk_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulse_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_BURST = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] len_q,     len_d;
    logic [GAP_W-1:0] gap_q,     gap_d;
    logic [REP_W-1:0] rep_q,     rep_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] pcnt_q,    pcnt_d;
    logic             clk_q,     clk_d;
    logic             abt_q,     abt_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // Next-state and next-output logic; every output is the register of its _d value.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        gap_d     = gap_q;
        rep_d     = rep_q;
        gap_cnt_d = gap_cnt_q;
        pcnt_d    = pcnt_q;
        clk_d     = 1'b0;
        abt_d     = abt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = burst_len;
                    gap_d   = gap_len;
                    rep_d   = repeat_cnt;
                    abt_d   = 1'b0;
                    pcnt_d  = '0;
                    state_d = (burst_len == '0) ? ST_DONE : ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    clk_d   = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // An abort during a high phase still completes (and counts) that pulse.
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = ST_DONE;
                    pcnt_d  = clk_q ? (pcnt_q + CNT_ONE) : pcnt_q;
                end else if (clk_q) begin
                    pcnt_d = pcnt_q + CNT_ONE;
                end else if (pcnt_q != len_q) begin
                    clk_d = 1'b1;
                end else if (rep_q != '0) begin
                    if (gap_q == '0) begin
                        clk_d  = 1'b1;
                        pcnt_d = '0;
                        rep_d  = rep_q - REP_ONE;
                    end else begin
                        gap_cnt_d = gap_q;
                        state_d   = ST_GAP;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    abt_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (gap_cnt_q == GAP_ONE) begin
                    clk_d   = 1'b1;
                    pcnt_d  = '0;
                    rep_d   = rep_q - REP_ONE;
                    state_d = ST_BURST;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ARM) || (state_d == ST_BURST) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    // State, configuration and output registers with synchronous reset.
    always_ff @(posedge fastclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            gap_q     <= '0;
            rep_q     <= '0;
            gap_cnt_q <= '0;
            pcnt_q    <= '0;
            clk_q     <= 1'b0;
            abt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            rep_q     <= rep_d;
            gap_cnt_q <= gap_cnt_d;
            pcnt_q    <= pcnt_d;
            clk_q     <= clk_d;
            abt_q     <= abt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign clk_out   = clk_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = abt_q;
    assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_clk_burst_ctrl.sv
// Bench for clk_burst_ctrl: builds the expected per-cycle output trace of each sequence
// from burst/gap/repeat arithmetic and compares the DUT against it cycle by cycle.
module tb_clk_burst_ctrl;

    logic       fastclk = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic [7:0] burst_len  = 8'd0;
    logic [7:0] gap_len    = 8'd0;
    logic [3:0] repeat_cnt = 4'd0;
    logic       clk_out, busy, done, aborted;
    logic [7:0] pulse_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit c;
        bit b;
        bit d;
        bit a;
        int p;
    } exp_t;

    exp_t exp_q[$];

    clk_burst_ctrl #(.CNT_W(8), .GAP_W(8), .REP_W(4)) dut (
        .fastclk    (fastclk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .repeat_cnt (repeat_cnt),
        .clk_out    (clk_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 fastclk = ~fastclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(bit c, bit b, bit d, bit a, int p);
        exp_t e;
        e.c = c; e.b = b; e.d = d; e.a = a; e.p = p;
        return e;
    endfunction

    // Expected outputs after the start edge, one entry per cycle, ending in IDLE.
    task automatic build(input int len, input int gap, input int rep, input int ak);
        int pc;
        exp_q.delete();
        if (len == 0) begin
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 0));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end else begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
            for (int bu = 0; bu <= rep; bu++) begin
                for (int p = 1; p <= len; p++) begin
                    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, p - 1));
                    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, p));
                end
                if (bu < rep)
                    for (int g = 0; g < gap; g++)
                        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, len));
            end
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, len));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, len));
        end
        if (ak >= 0) begin
            pc = exp_q[ak].p + int'(exp_q[ak].c);
            while (exp_q.size() > ak + 1) void'(exp_q.pop_back());
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, pc));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, pc));
        end
    endtask

    // Start one sequence from the current IDLE cycle; returns in the final IDLE cycle.
    task automatic run_seq(input int len, input int gap, input int rep, input int ak, input bit hold);
        int last;
        build(len, gap, rep, ak);
        last       = exp_q.size() - 1;
        start      = 1'b1;
        burst_len  = 8'(len);
        gap_len    = 8'(gap);
        repeat_cnt = 4'(rep);
        abort      = 1'($urandom_range(0, 1));
        @(posedge fastclk); #1;
        for (int j = 0; j <= last; j++) begin
            chk($sformatf("clk_out[%0d]", j),   32'(clk_out),   32'(exp_q[j].c));
            chk($sformatf("busy[%0d]", j),      32'(busy),      32'(exp_q[j].b));
            chk($sformatf("done[%0d]", j),      32'(done),      32'(exp_q[j].d));
            chk($sformatf("aborted[%0d]", j),   32'(aborted),   32'(exp_q[j].a));
            chk($sformatf("pulse_cnt[%0d]", j), 32'(pulse_cnt), 32'(exp_q[j].p));
            burst_len  = 8'($urandom);
            gap_len    = 8'($urandom);
            repeat_cnt = 4'($urandom);
            if (exp_q[j].b) begin
                abort = (j == ak);
                start = hold;
            end else begin
                abort = 1'($urandom_range(0, 1));
                start = (j == last) ? 1'b0 : hold;
            end
            if (j < last) begin
                @(posedge fastclk); #1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int len, gap, rep, ak, nbusy;
        repeat (2) @(posedge fastclk);
        #1;
        reset = 1'b0;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);

        run_seq(3, 0, 0, -1, 1'b0);
        run_seq(2, 4, 2, -1, 1'b0);
        run_seq(0, 3, 1, -1, 1'b0);
        run_seq(8, 0, 0, 9, 1'b0);
        run_seq(1, 0, 0, -1, 1'b1);
        run_seq(1, 0, 0, -1, 1'b1);
        run_seq(1, 0, 0, -1, 1'b1);
        run_seq(3, 0, 2, -1, 1'b0);
        run_seq(2, 1, 1, 6, 1'b0);

        // Reset in the middle of a long burst, then a clean sequence.
        start = 1'b1; burst_len = 8'd10; gap_len = 8'd0; repeat_cnt = 4'd0;
        @(posedge fastclk); #1;
        start = 1'b0;
        repeat (4) @(posedge fastclk);
        #1;
        reset = 1'b1;
        @(posedge fastclk); #1;
        reset = 1'b0;
        chk("midrst_clk_out", 32'(clk_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_pulse_cnt", 32'(pulse_cnt), 32'd0);
        @(posedge fastclk); #1;
        chk("postrst_clk_out", 32'(clk_out), 32'd0);
        chk("postrst_done", 32'(done), 32'd0);
        run_seq(10, 0, 0, -1, 1'b0);

        for (int s = 0; s < 30; s++) begin
            len = $urandom_range(0, 6);
            gap = $urandom_range(0, 4);
            rep = $urandom_range(0, 3);
            ak  = -1;
            if (len != 0 && $urandom_range(0, 2) == 0) begin
                nbusy = 1 + (rep + 1) * 2 * len + rep * gap;
                ak = $urandom_range(0, nbusy - 1);
            end
            run_seq(len, gap, rep, ak, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_burst_ctrl.md
CLK_BURST_CTRL -- requirements
Module: clk_burst_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of burst_len and pulse_cnt.
REQ-002 SHALL have parameter GAP_W, default 8, width of gap_len.
REQ-003 SHALL have parameter REP_W, default 4, width of repeat_cnt.
REQ-004 fastclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to begin a sequence; sampled in IDLE only.
REQ-007 abort  input  1  terminate the active sequence; sampled in ARM/BURST/GAP.
REQ-008 burst_len  input  CNT_W  clock pulses per burst.
REQ-009 gap_len  input  GAP_W  extra low cycles between bursts.
REQ-010 repeat_cnt  input  REP_W  additional bursts after the first; total bursts = repeat_cnt+1.
REQ-011 clk_out  output  1  registered gated clock, fastclk/2 during bursts, 0 otherwise.
REQ-012 busy  output  1  high in ARM, BURST, GAP.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 aborted  output  1  sticky flag: last sequence ended by abort.
REQ-015 pulse_cnt  output  CNT_W  pulses completed in the current burst.

Function
REQ-016 SHALL implement states IDLE, ARM, BURST, GAP, DONE; all outputs registered.
REQ-017 IDLE: clk_out=0, busy=0; start=1 latches burst_len, gap_len, repeat_cnt, clears aborted, and moves to ARM, or to DONE if burst_len=0.
REQ-018 Inputs burst_len/gap_len/repeat_cnt changing while busy SHALL have no effect; latched copies are used.
REQ-019 ARM: exactly one cycle, clk_out=0, then BURST with clk_out<=1 on the same edge.
REQ-020 BURST: clk_out toggles every fastclk cycle, starting high; one pulse = 1 high + 1 low cycle.
REQ-021 pulse_cnt SHALL increment on each 1->0 update of clk_out; it SHALL clear to 0 on entry to ARM and on the start of each new burst.
REQ-022 On the falling update completing pulse burst_len: if repeats remain, go to GAP (or directly to the next burst when gap_len=0); otherwise go to DONE.
REQ-023 GAP: clk_out=0 for gap_len cycles; the low time between the last falling and next rising of clk_out SHALL be exactly gap_len+1 fastclk cycles.
REQ-024 gap_len=0 SHALL yield an unbroken fastclk/2 clock across bursts.
REQ-025 Remaining-repeat counter SHALL decrement at each new burst start; no wrap-around below 0.
REQ-026 DONE: exactly one cycle, done=1, busy=0, clk_out=0; then IDLE; start held high through DONE SHALL be ignored until IDLE.
REQ-027 Back-to-back: start=1 in the IDLE cycle following DONE SHALL begin a new sequence.
REQ-028 Latency: start sampled at edge t -> busy=1 after t, clk_out=1 after t+1; a burst of N pulses spans 2N cycles.
REQ-029 abort=1 in ARM/BURST/GAP: next state DONE, clk_out<=0, aborted<=1; if clk_out was 1, that pulse counts in pulse_cnt.
REQ-030 abort and the final falling update in the same cycle: abort wins, aborted=1.
REQ-031 abort in IDLE or DONE SHALL be ignored; start and abort together in IDLE: start accepted, abort ignored.
REQ-032 clk_out SHALL never produce a high phase shorter than one fastclk cycle (glitch-free).

Reset
REQ-033 reset=1 at a rising edge SHALL force IDLE, clk_out=0, busy=0, done=0, aborted=0, pulse_cnt=0, and clear all latched configuration and counters.
REQ-034 Reset mid-burst SHALL take effect on the next edge, with no further clk_out pulse and no done pulse.

Verification
REQ-035 burst_len=3, gap_len=0, repeat_cnt=0, start pulse -> clk_out 1,0,1,0,1,0 from cycle t+2, pulse_cnt 1..3, done high one cycle, busy low.
REQ-036 burst_len=2, gap_len=4, repeat_cnt=2 -> three 2-pulse bursts, each separated by 5 low cycles, single done at the end.
REQ-037 burst_len=0, start -> no clk_out activity, done high in the cycle after start is sampled, busy never high.
REQ-038 burst_len=8, abort asserted while clk_out=1 after pulse 4 is high -> clk_out 0 next cycle, pulse_cnt=5, done=1, aborted=1.
REQ-039 burst_len=10, reset asserted mid-burst -> all outputs 0 on the next edge; start afterwards runs a clean full sequence.
REQ-040 start held high continuously with burst_len=1, repeat_cnt=0 -> repeated sequences IDLE->ARM->BURST(2)->DONE->IDLE, 5-cycle period.
